// File: rtl/debounced_count_controller.sv
// Debounce/pulse/settle/sample sequencer driving an external asynchronous ripple counter.
// Optional DEBOUNCED_COUNT_SATURATE_EN adds a 'saturated' output and stops counting at all-ones.
module debounced_count_controller #(
    parameter int SIZE            = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 2,
    parameter int SETTLE_CYCLES   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            button,
    input  logic            clear,
    input  logic [SIZE-1:0] count_value,
    output logic            up,
    output logic            counter_reset,
    output logic [SIZE-1:0] snapshot,
    output logic            snapshot_valid,
    output logic            busy
`ifdef DEBOUNCED_COUNT_SATURATE_EN
    ,
    output logic            saturated
`endif
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_INIT_CLEAR,
        S_CLEAR_SETTLE,
        S_IDLE,
        S_PULSE,
        S_SETTLE,
        S_SAMPLE,
        S_HELD_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            btn_meta_q, btn_sync_q;
    logic            db_level_q, db_level_d;
    logic [DBW-1:0]  db_cnt_q, db_cnt_d;
    logic            press_acc;
    logic [SIZE-1:0] cap_q;
    logic            cap_en;
    logic [SIZE-1:0] snapshot_q, snapshot_d;
    logic            snap_valid_q, snap_valid_d;
    logic            up_q, counter_reset_q, busy_q;
    logic            sat_q, sat_d;

    // Debouncer: count consecutive samples that differ from the accepted level
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = db_cnt_q;
        press_acc  = 1'b0;
        if (btn_sync_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
            db_level_d = btn_sync_q;
            db_cnt_d   = '0;
            press_acc  = btn_sync_q;
        end else begin
            db_cnt_d = db_cnt_q + DBW'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        snapshot_d   = snapshot_q;
        snap_valid_d = 1'b0;
        sat_d        = sat_q;
        cap_en       = 1'b0;
        case (state_q)
            S_INIT_CLEAR: begin
                tmr_d = tmr_q + TW'(1);
                if (tmr_q == TW'(1)) begin
                    state_d = S_CLEAR_SETTLE;
                    tmr_d   = '0;
                end
            end
            S_CLEAR_SETTLE: begin
                tmr_d = tmr_q + TW'(1);
                if (tmr_q == TW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_SAMPLE;
                    tmr_d   = '0;
                end
            end
            S_IDLE: begin
                if (press_acc) begin
`ifdef DEBOUNCED_COUNT_SATURATE_EN
                    if (&snapshot_q) begin
                        state_d = S_HELD_WAIT;
                        sat_d   = 1'b1;
                    end else begin
                        state_d = S_PULSE;
                        tmr_d   = '0;
                    end
`else
                    state_d = S_PULSE;
                    tmr_d   = '0;
`endif
                end
            end
            S_PULSE: begin
                // timer keeps running into SETTLE so settling is measured from the up edge
                tmr_d = tmr_q + TW'(1);
                if (tmr_q == TW'(PULSE_CYCLES - 1)) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                tmr_d = tmr_q + TW'(1);
                if (tmr_q >= TW'(SETTLE_CYCLES - 1)) begin
                    state_d = S_SAMPLE;
                    tmr_d   = '0;
                end
            end
            S_SAMPLE: begin
                cap_en = 1'b1;
                tmr_d  = tmr_q + TW'(1);
                if (tmr_q == TW'(1)) begin
                    snapshot_d   = cap_q;
                    snap_valid_d = 1'b1;
                    state_d      = db_level_q ? S_HELD_WAIT : S_IDLE;
                    tmr_d        = '0;
                end
            end
            S_HELD_WAIT: begin
                if (!db_level_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT_CLEAR;
                tmr_d   = '0;
            end
        endcase
        // clear overrides everything outside the clear sequence, including a same-cycle press
        if (clear && state_q != S_INIT_CLEAR && state_q != S_CLEAR_SETTLE) begin
            state_d      = S_INIT_CLEAR;
            tmr_d        = '0;
            snap_valid_d = 1'b0;
            sat_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_INIT_CLEAR;
            tmr_q           <= '0;
            btn_meta_q      <= 1'b0;
            btn_sync_q      <= 1'b0;
            db_level_q      <= 1'b0;
            db_cnt_q        <= '0;
            cap_q           <= '0;
            snapshot_q      <= '0;
            snap_valid_q    <= 1'b0;
            up_q            <= 1'b0;
            counter_reset_q <= 1'b1;
            busy_q          <= 1'b1;
            sat_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            tmr_q           <= tmr_d;
            btn_meta_q      <= button;
            btn_sync_q      <= btn_meta_q;
            db_level_q      <= db_level_d;
            db_cnt_q        <= db_cnt_d;
            if (cap_en) cap_q <= count_value;
            snapshot_q      <= snapshot_d;
            snap_valid_q    <= snap_valid_d;
            // registered so the asynchronous counter never sees decode glitches
            up_q            <= (state_d == S_PULSE);
            counter_reset_q <= (state_d == S_INIT_CLEAR);
            busy_q          <= !(state_d == S_IDLE || state_d == S_HELD_WAIT);
            sat_q           <= sat_d;
        end
    end

    assign up             = up_q;
    assign counter_reset  = counter_reset_q;
    assign snapshot       = snapshot_q;
    assign snapshot_valid = snap_valid_q;
    assign busy           = busy_q;
`ifdef DEBOUNCED_COUNT_SATURATE_EN
    assign saturated      = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule
